// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader sits on the master side; the byte source and the memory sit on
// the slave side.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Receives a 16-bit little-endian word
// count followed by little-endian 32-bit words over a byte stream, writes
// each word with a one-cycle strobe, and releases the core only after the
// whole program has been written.
module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          core_hold
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [31:0]      wdata;
    logic [31:0]      addr;
    logic             rx_open;
    logic             accept;
    logic             last_word;
    logic [15:0]      hdr_len;

    // The stream is open only while a header or data byte is expected.
    assign rx_open   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    assign accept    = bus.rx_valid && rx_open;
    // Full header value as it becomes known on the high-byte accept.
    assign hdr_len   = {bus.rx_data, count[7:0]};
    assign last_word = (word_idx == count - CNT_W'(1));

    assign bus.rx_ready   = rx_open;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = wdata;

    // State register; reset abandons any load in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every register samples pre-edge values, independent of block order.
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        // NOTE: every output gets a default first; a path that skips an
        // assignment would otherwise infer a latch.
        state_nxt    = state;
        bus.imem_we  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        core_hold    = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                busy = 1'b1;
                if (accept) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                busy = 1'b1;
                if (accept) begin
                    if (hdr_len == 16'd0)               state_nxt = DONE;
                    else if ({1'b0, hdr_len} > DEPTH_L) state_nxt = ERR;
                    else                                state_nxt = DATA;
                end
            end
            DATA: begin
                busy = 1'b1;
                if (accept && byte_idx == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                bus.imem_we = 1'b1;
                state_nxt   = last_word ? DONE : DATA;
            end
            DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
                if (start) state_nxt = LEN_LO;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_nxt = LEN_LO;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Header capture, byte assembly and write-address generation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the word assembly register is ordinary flops, not a RAM,
            // so it is reset with everything else to give known bus values.
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            wdata    <= '0;
            addr     <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                LEN_LO: begin
                    if (accept) count[7:0] <= bus.rx_data;
                end
                LEN_HI: begin
                    if (accept) count <= CNT_W'(hdr_len);
                end
                DATA: begin
                    if (accept) begin
                        wdata[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
                        byte_idx                       <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3)
                            addr <= BASE_ADDR + 32'({word_idx, 2'b00});
                    end
                end
                WRITE: begin
                    if (!last_word) word_idx <= word_idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// loads, each compared against a reference built from the stream contents.
module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done, err, core_hold;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  stream[$];

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .core_hold(core_hold)
    );

    always #5 clk = ~clk;

    // Log every write the memory would see.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles and wait (bounded) for its accept.
    task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
        logic ok;
        ok = 1'b0;
        bus.rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        check1({tag, "_accept"}, ok, 1'b1);
    endtask

    // Header plus 'n' random words into 'stream' (only header if data==0).
    task automatic build_stream(input int n, input bit with_data);
        logic [15:0] c;
        c = 16'(n);
        stream.delete();
        stream.push_back(c[7:0]);
        stream.push_back(c[15:8]);
        if (with_data)
            for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    endtask

    // Run one load of 'stream' and compare against the reference outcome.
    task automatic run_load(input string tag, input int gap_lo, input int gap_hi, input int start_at);
        int cnt, exp_n, n_cmp;
        logic [31:0] exp_word;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        check1({tag, "_busy_after_start"}, busy, 1'b1);
        check1({tag, "_hold_after_start"}, core_hold, 1'b1);
        for (int i = 0; i < stream.size(); i++) begin
            if (i == start_at) begin
                check1({tag, "_busy_at_restart"}, busy, 1'b1);
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            send_byte(stream[i], $urandom_range(gap_hi, gap_lo), tag);
        end
        cnt   = {stream[1], stream[0]};
        exp_n = (cnt > DEPTH) ? 0 : cnt;
        if (cnt == 0 || cnt > DEPTH) begin
            @(negedge clk);
            check1({tag, "_done"}, done, cnt == 0);
            check1({tag, "_err"}, err, cnt > DEPTH);
            check1({tag, "_hold"}, core_hold, cnt > DEPTH);
            check1({tag, "_ready_idle"}, bus.rx_ready, 1'b0);
            check1({tag, "_busy_end"}, busy, 1'b0);
        end else begin
            @(negedge clk);
            check1({tag, "_we_latency"}, bus.imem_we, 1'b1);
            @(negedge clk);
            check1({tag, "_done"}, done, 1'b1);
            check1({tag, "_hold"}, core_hold, 1'b0);
            check1({tag, "_we_end"}, bus.imem_we, 1'b0);
            check1({tag, "_ready_idle"}, bus.rx_ready, 1'b0);
        end
        check32({tag, "_n_writes"}, 32'(wr_addr_q.size()), 32'(exp_n));
        n_cmp = (wr_addr_q.size() < exp_n) ? wr_addr_q.size() : exp_n;
        for (int i = 0; i < n_cmp; i++) begin
            exp_word = {stream[2 + 4*i + 3], stream[2 + 4*i + 2],
                        stream[2 + 4*i + 1], stream[2 + 4*i]};
            check32($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
            check32($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_word);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_ready"}, bus.rx_ready, 1'b0);
        check1({tag, "_we"}, bus.imem_we, 1'b0);
        check32({tag, "_addr"}, bus.imem_addr, 32'h0);
        check32({tag, "_wdata"}, bus.imem_wdata, 32'h0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
        check1({tag, "_hold"}, core_hold, 1'b1);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state.
        #3;
        check_reset_values("rst");
        @(posedge clk); #1 reset = 1'b1;

        // Two-word load with rx_valid held high.
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load("two_word", 0, 0, -1);
        if (wr_data_q.size() == 2) begin
            check32("two_word_w0_const", wr_data_q[0], 32'h0000_0013);
            check32("two_word_w1_const", wr_data_q[1], 32'h0010_0093);
            check32("two_word_a1_const", wr_addr_q[1], 32'h0000_0004);
        end else begin
            check32("two_word_count_const", 32'(wr_data_q.size()), 32'd2);
        end

        // Zero length.
        stream = '{8'h00, 8'h00};
        run_load("zero_len", 0, 0, -1);

        // Overflow: 257 words requested; extra byte must be refused.
        stream = '{8'h01, 8'h01};
        run_load("overflow", 0, 0, -1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("overflow_refuse_ready", bus.rx_ready, 1'b0);
            check1("overflow_stays_err", err, 1'b1);
        end
        bus.rx_valid = 1'b0;
        check32("overflow_no_write", 32'(wr_addr_q.size()), 32'd0);

        // Backpressure: rx_valid 1,0,0,1 between bytes.
        stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load("gaps", 2, 2, -1);
        if (wr_data_q.size() == 1)
            check32("gaps_word_const", wr_data_q[0], 32'hDEAD_BEEF);

        // Reset mid-load after 2 of 4 data bytes.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h01, 0, "midrst");
        send_byte(8'h00, 0, "midrst");
        send_byte(8'h11, 0, "midrst");
        send_byte(8'h22, 0, "midrst");
        #3 reset = 1'b0;
        #1;
        check_reset_values("midrst_async");
        check32("midrst_no_write", 32'(wr_addr_q.size()), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        build_stream(1, 1'b1);
        run_load("after_rst", 0, 1, -1);

        // start pulsed during DATA is ignored.
        build_stream(3, 1'b1);
        run_load("start_busy", 0, 1, 7);

        // Exact-capacity load.
        build_stream(DEPTH, 1'b1);
        run_load("full_depth", 0, 0, -1);

        // Randomized loads, occasionally oversized.
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(4, 0) == 0)
                build_stream(DEPTH + 1 + $urandom_range(2000, 0), 1'b0);
            else
                build_stream($urandom_range(6, 1), 1'b1);
            run_load($sformatf("rand%0d", k), 0, 3, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory; the write-side counterpart of the fetch path (program_counter -> instruction_memory read).
- Takes a byte stream with a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues single-cycle write strobes to the instruction memory write port.
- Holds the core (PC / register file) in hold until a complete program has been loaded.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- CNT_W, 16, width of the word-count header field and word counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_valid  input  1  byte-stream valid.
- rx_data  input  8  byte-stream data.
- rx_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the word being written.
- imem_wdata  output  32  assembled instruction word.
- busy  output  1  high in LEN_LO, LEN_HI, DATA and WRITE.
- done  output  1  load completed successfully; level signal.
- err  output  1  header word count exceeds DEPTH; level signal.
- core_hold  output  1  high keeps the CPU held; low only in DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, core_hold=1. All counters are cleared. Reset during a load abandons it; words already written stay in memory, but core_hold stays 1.
- Byte accept: a byte is accepted when rx_valid && rx_ready are both high at a rising clk edge. rx_data is don't-care otherwise. rx_valid may drop at any time; the loader simply waits.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE: rx_ready=0. start moves to LEN_LO, clears word_idx, byte_idx, done and err, and sets core_hold=1.
- LEN_LO: rx_ready=1. On accept, count[7:0]=rx_data, then go to LEN_HI.
- LEN_HI: rx_ready=1. On accept, count[15:8]=rx_data. The next state is decided from the full count:
  - count==0 -> DONE (no writes).
  - count>DEPTH -> ERR.
  - otherwise -> DATA.
- DATA: rx_ready=1. The byte accepted with byte_idx=k goes to wdata bits [8k+7:8k], so the first byte is the LSB. byte_idx increments from 0 to 3. On accepting the byte at byte_idx=3, byte_idx wraps to 0 and the state moves to WRITE.
- WRITE: rx_ready=0 and imem_we=1 for exactly one cycle.
  - imem_addr = BASE_ADDR + (word_idx << 2); byte addressing, consistent with the PC.
  - imem_wdata holds the assembled word.
  - Write latency: the strobe is asserted in the cycle after the 4th byte is accepted.
  - Next: if word_idx == count-1, go to DONE; else word_idx increments and the state returns to DATA.
- DONE: done=1, core_hold=0, rx_ready=0. start begins a new load.
- ERR: err=1, core_hold=1, rx_ready=0. No writes occur. Only start or reset exits this state.
- start is ignored while busy=1.
- Bytes presented while rx_ready=0 are not consumed; the source must hold them.
- imem_addr and imem_wdata may hold stale values when imem_we=0. The memory must sample them only with the strobe.
- word_idx never exceeds DEPTH-1, because the count is checked before any write.
- Simultaneous start and reset: reset wins.

Test Plan:
1. Two-word load:
   - Stimulus: start, then bytes 02 00 | 13 00 00 00 | 93 00 10 00 with rx_valid held high.
   - Required: two imem_we pulses, addr 0x0 / wdata 0x00000013, then addr 0x4 / wdata 0x00100093. done=1 and core_hold=0 in the cycle after the 2nd pulse.
2. Zero length:
   - Stimulus: start, bytes 00 00.
   - Required: no imem_we pulse; done=1, core_hold=0 two accepts after start; rx_ready=0 afterwards.
3. Overflow (DEPTH=256):
   - Stimulus: start, bytes 01 01 (count=257).
   - Required: err=1, core_hold=1, no imem_we; a following data byte is not accepted (rx_ready=0).
4. Backpressure/gaps:
   - Stimulus: one-word load with rx_valid toggling 1,0,0,1 between bytes.
   - Required: imem_wdata=0xDEADBEEF from bytes EF BE AD DE, a single write to BASE_ADDR, and no duplicated or skipped bytes.
5. Reset mid-load:
   - Stimulus: assert reset after 2 of 4 data bytes.
   - Required: all outputs return to reset values immediately (asynchronously), core_hold=1. A new start plus a full one-word stream writes to address 0 correctly.
6. start while busy:
   - Stimulus: pulse start during DATA.
   - Required: no effect; the load completes normally with the correct word count and addresses.
